// File: rtl/spi_master_if.sv
// Bus bundle between the SPI master and whatever drives or observes it.
// The master modport is the controller's own view.
interface spi_master_if #(
    parameter int DATA_BIT_WIDTH = 16
);
    logic                      EN;
    logic                      SCK;
    logic                      MOSI;
    logic                      MISO;
    logic                      SEL;
    logic                      START;
    logic                      BUSY;
    logic                      VALID;
    logic [DATA_BIT_WIDTH-1:0] DATA_OUT;
    logic [DATA_BIT_WIDTH-1:0] DATA_IN;

    modport master (
        input  EN, MISO, START, DATA_IN,
        output SCK, MOSI, SEL, BUSY, VALID, DATA_OUT
    );

    modport slave (
        output EN, MISO, START, DATA_IN,
        input  SCK, MOSI, SEL, BUSY, VALID, DATA_OUT
    );
endinterface

// File: rtl/spi_master.sv
// Single-channel SPI master: one word out on MOSI, one word in from MISO,
// MSB first, with configurable clock polarity, phase and SCK divider.
//
// state | meaning
// IDLE  | SEL low, waiting for an accepted START
// LEAD  | SEL high, SCK parked at idle level for one half period
// SHIFT | SCK toggling, one edge per half period, 2*DATA_BIT_WIDTH edges
// TRAIL | SEL held high for one half period after the last edge
module spi_master #(
    parameter int DATA_BIT_WIDTH  = 16,
    parameter bit CPOL            = 1'b0,
    parameter bit CPHA            = 1'b1,
    parameter int SCK_HALF_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_master_if.master bus
);
    localparam int W      = DATA_BIT_WIDTH;
    localparam int CNT_W  = (SCK_HALF_CYCLES > 1) ? $clog2(SCK_HALF_CYCLES) : 1;
    localparam int EDGE_W = $clog2(2 * W);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SCK_HALF_CYCLES - 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [EDGE_W-1:0]   edge_q;
    logic [W-1:0]        tx_q;
    logic [W-1:0]        rx_q;
    logic [W-1:0]        dout_q;
    logic                sck_q;
    logic                mosi_q;
    logic                sel_q;
    logic                busy_q;
    logic                valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.EN) begin
                // Abort: drop the bus immediately, keep the last good DATA_OUT.
                state_q <= IDLE;
                cnt_q   <= '0;
                edge_q  <= '0;
                sck_q   <= CPOL;
                mosi_q  <= 1'b0;
                sel_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.START) begin
                            state_q <= LEAD;
                            cnt_q   <= CNT_RELOAD;
                            edge_q  <= '0;
                            rx_q    <= '0;
                            sck_q   <= CPOL;
                            sel_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            if (CPHA) begin
                                tx_q <= bus.DATA_IN;
                            end else begin
                                mosi_q <= bus.DATA_IN[W-1];
                                tx_q   <= {bus.DATA_IN[W-2:0], 1'b0};
                            end
                        end
                    end
                    LEAD: begin
                        if (cnt_q == '0) begin
                            state_q <= SHIFT;
                            cnt_q   <= CNT_RELOAD;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (cnt_q == '0) begin
                            cnt_q  <= CNT_RELOAD;
                            sck_q  <= ~sck_q;
                            edge_q <= edge_q + EDGE_W'(1);
                            // Even edge index is the leading edge of an SCK period.
                            if (edge_q[0] == CPHA) begin
                                rx_q <= {rx_q[W-2:0], bus.MISO};
                            end else if (edge_q != LAST_EDGE) begin
                                mosi_q <= tx_q[W-1];
                                tx_q   <= {tx_q[W-2:0], 1'b0};
                            end
                            if (edge_q == LAST_EDGE) begin
                                state_q <= TRAIL;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    TRAIL: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            sel_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            mosi_q  <= 1'b0;
                            dout_q  <= rx_q;
                            valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.SCK      = sck_q;
    assign bus.MOSI     = mosi_q;
    assign bus.SEL      = sel_q;
    assign bus.BUSY     = busy_q;
    assign bus.VALID    = valid_q;
    assign bus.DATA_OUT = dout_q;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: default-mode instance with a selectable
// slave model, plus a CPOL=1/CPHA=0/divider-1 instance in loopback.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_BIT_WIDTH(16)) if0 ();
    spi_master_if #(.DATA_BIT_WIDTH(16)) if1 ();

    spi_master #(.DATA_BIT_WIDTH(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    spi_master #(.DATA_BIT_WIDTH(16), .CPOL(1'b1), .CPHA(1'b0), .SCK_HALF_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave models: 0 = MISO tied high, 1 = loopback, 2 = shift-register slave
    int          miso_mode = 0;
    logic [15:0] slave_word = '0;
    logic        slave_bit = 1'b0;
    int          sl_idx = -1;

    assign if0.MISO = (miso_mode == 0) ? 1'b1 : (miso_mode == 1) ? if0.MOSI : slave_bit;
    assign if1.MISO = if1.MOSI;

    // Mode 0/1 slave: presents the next bit on each rising SCK, MSB first.
    always @(posedge if0.SEL) sl_idx = 15;
    always @(posedge if0.SCK) begin
        if (sl_idx >= 0) begin
            slave_bit = slave_word[sl_idx];
            sl_idx--;
        end
    end

    typedef struct {
        logic [15:0] rx;
        logic [15:0] tx;
    } exp_t;

    exp_t        q0[$];
    logic [15:0] q1[$];
    logic [15:0] model_dout0 = '0;

    // Monitor for dut0
    logic        sck_p = 1'b0, sel_p = 1'b0, busy_p = 1'b0;
    int          rises = 0, busy_cyc = 0;
    logic [15:0] mosi_w = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (if0.SEL && !sel_p) begin
                rises  = 0;
                mosi_w = '0;
            end
            if (if0.BUSY && !busy_p) busy_cyc = 0;
            if (if0.BUSY) busy_cyc++;
            if (if0.SCK && !sck_p) rises++;
            if (!if0.SCK && sck_p) mosi_w = {mosi_w[14:0], if0.MOSI};
            if (if0.VALID) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid0: got VALID=1 expected no completing transfer at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    check("data_out0", 32'(if0.DATA_OUT), 32'(e.rx));
                    check("mosi_word0", 32'(mosi_w), 32'(e.tx));
                    check("sck_rises0", rises, 16);
                    check("busy_len0", busy_cyc, 68);
                    check("sel_at_valid0", 32'(if0.SEL), 0);
                end
            end
        end
        sck_p  = if0.SCK;
        sel_p  = if0.SEL;
        busy_p = if0.BUSY;
    end

    // Monitor for dut1
    logic b1_p = 1'b0;
    int   b1_cyc = 0;
    always @(negedge clk) begin
        logic [15:0] e1;
        if (rst_n) begin
            if (if1.BUSY && !b1_p) b1_cyc = 0;
            if (if1.BUSY) b1_cyc++;
            if (if1.VALID) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid1: got VALID=1 expected no completing transfer at %0t", $time);
                end else begin
                    e1 = q1.pop_front();
                    check("data_out1", 32'(if1.DATA_OUT), 32'(e1));
                    check("busy_len1", b1_cyc, 34);
                end
            end
        end
        b1_p = if1.BUSY;
    end

    task automatic wait_idle0(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if0.BUSY && n < budget);
        check("idle_timeout0", 32'(if0.BUSY), 0);
    endtask

    // Called just after a negedge; returns one negedge later with START low.
    task automatic issue0(input logic [15:0] d, input int mode, input logic [15:0] sw, input bit push);
        exp_t e;
        miso_mode  = mode;
        slave_word = sw;
        e.tx = d;
        e.rx = (mode == 0) ? 16'hFFFF : (mode == 1) ? d : sw;
        if (push) begin
            q0.push_back(e);
            model_dout0 = e.rx;
        end
        if0.DATA_IN = d;
        if0.START   = 1'b1;
        @(negedge clk);
        if0.START   = 1'b0;
        if0.DATA_IN = 16'($urandom);
    endtask

    task automatic xfer0(input logic [15:0] d, input int mode, input logic [15:0] sw);
        issue0(d, mode, sw, 1'b1);
        wait_idle0(200);
    endtask

    task automatic xfer1(input logic [15:0] d);
        int n = 0;
        q1.push_back(d);
        if1.DATA_IN = d;
        if1.START   = 1'b1;
        @(negedge clk);
        if1.START   = 1'b0;
        if1.DATA_IN = 16'($urandom);
        do begin
            @(negedge clk);
            n++;
        end while (if1.BUSY && n < 100);
        check("idle_timeout1", 32'(if1.BUSY), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        if0.EN = 1'b0; if0.START = 1'b0; if0.DATA_IN = '0;
        if1.EN = 1'b0; if1.START = 1'b0; if1.DATA_IN = '0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_sck0", 32'(if0.SCK), 0);
        check("rst_sel0", 32'(if0.SEL), 0);
        check("rst_busy0", 32'(if0.BUSY), 0);
        check("rst_valid0", 32'(if0.VALID), 0);
        check("rst_dout0", 32'(if0.DATA_OUT), 0);
        check("rst_mosi0", 32'(if0.MOSI), 0);
        check("rst_sck1", 32'(if1.SCK), 1);
        @(negedge clk);
        rst_n = 1'b1;
        if0.EN = 1'b1;
        if1.EN = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_sel0", 32'(if0.SEL), 0);
        check("idle_busy0", 32'(if0.BUSY), 0);
        check("idle_sck0", 32'(if0.SCK), 0);

        xfer0(16'hD10D, 0, 16'h0000);

        // Chaining in loopback: back-to-back and 10-cycle gaps
        for (int i = 0; i < 6; i++) begin
            int gap;
            gap = (i % 2 == 0) ? 10 : 0;
            repeat (gap) @(negedge clk);
            xfer0(16'hACAC, 1, 16'h0000);
        end

        for (int i = 0; i < 10; i++) begin
            int gap;
            gap = int'($urandom_range(0, 6));
            repeat (gap) @(negedge clk);
            xfer0(16'($urandom), int'($urandom_range(0, 2)), 16'($urandom));
        end

        // START during BUSY must be ignored
        issue0(16'hD10D, 2, 16'h5A3C, 1'b1);
        repeat (30) @(negedge clk);
        if0.DATA_IN = 16'h1234;
        if0.START   = 1'b1;
        @(negedge clk);
        if0.START   = 1'b0;
        wait_idle0(200);
        repeat (5) @(negedge clk);
        check("no_extra_busy0", 32'(if0.BUSY), 0);

        // EN abort after five SCK periods
        issue0(16'h5A5A, 1, 16'h0000, 1'b0);
        repeat (21) @(negedge clk);
        if0.EN = 1'b0;
        @(negedge clk);
        check("abort_sel0", 32'(if0.SEL), 0);
        check("abort_busy0", 32'(if0.BUSY), 0);
        check("abort_sck0", 32'(if0.SCK), 0);
        check("abort_mosi0", 32'(if0.MOSI), 0);
        repeat (80) @(negedge clk);
        check("abort_dout0", 32'(if0.DATA_OUT), 32'(model_dout0));
        if0.EN = 1'b1;
        @(negedge clk);
        xfer0(16'hACAC, 1, 16'h0000);

        // Second configuration: SCK idles high, 34-cycle transfers
        check("idle_sck1", 32'(if1.SCK), 1);
        xfer1(16'h8001);
        for (int i = 0; i < 4; i++) xfer1(16'($urandom));
        check("end_sck1", 32'(if1.SCK), 1);

        // Asynchronous reset in the middle of a transfer
        issue0(16'($urandom), 1, 16'h0000, 1'b0);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dout0", 32'(if0.DATA_OUT), 0);
        check("midrst_sel0", 32'(if0.SEL), 0);
        check("midrst_busy0", 32'(if0.BUSY), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_dout0 = '0;
        @(negedge clk);
        xfer0(16'h3C3C, 2, 16'hC0DE);

        repeat (10) @(negedge clk);
        check("queue_empty0", q0.size(), 0);
        check("queue_empty1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
